// File: rtl/wash_ctrl.sv
// wash_ctrl -- washing-machine program sequencer.
//
// Takes clean one-cycle key pulses from the debouncers and steps through the
// timed phases FILL -> WASH -> DRAIN -> SPIN -> DONE. It drives the valves,
// the motor and the status outputs, and exports the seconds left in the
// current phase for the display.
//
// Optional feature: define WASH_BUZZER_EN to enable the done-alert buzzer.
// When the macro is undefined, buzzer is tied low and no buzzer counter
// is built.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   key_start  start / pause-resume / acknowledge pulse
//   key_mode   program-mode select pulse (honoured only in IDLE)
//   key_stop   abort-to-IDLE pulse
//   phase      0=IDLE 1=FILL 2=WASH 3=DRAIN 4=SPIN 5=DONE
//   mode       0=quick 1=normal 2=heavy
//   remain_s   seconds left in the current phase
//   paused     high while an active phase is paused
//   valve_in   fill valve
//   valve_out  drain valve
//   motor      drum motor
//   buzzer     done alert
module wash_ctrl #(
  parameter int         CLK_HZ  = 24_000_000,
  parameter logic [7:0] FILL_S  = 8'd10,
  parameter logic [7:0] WASH_S  = 8'd30,
  parameter logic [7:0] DRAIN_S = 8'd10,
  parameter logic [7:0] SPIN_S  = 8'd20,
  parameter logic [7:0] BUZZ_S  = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_mode,
  input  logic       key_stop,
  output logic [2:0] phase,
  output logic [1:0] mode,
  output logic [7:0] remain_s,
  output logic       paused,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor,
  output logic       buzzer
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;
  localparam logic [2:0] PH_DONE  = 3'd5;

  logic [2:0]    phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    remain_q, remain_d;
  logic          paused_q, paused_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          active, run, count_en, tick, advance;
  logic [2:0]    next_ph;
`ifdef WASH_BUZZER_EN
  logic [7:0]    buzz_q, buzz_d;
  logic          buzzing;
`else
  logic          unused_buzz;
  assign unused_buzz = ^BUZZ_S;
`endif

  // Duration in seconds of a phase; wash time scales with the program mode.
  function automatic logic [7:0] phase_dur(input logic [2:0] ph, input logic [1:0] md);
    logic [7:0] mult;
    mult = {6'd0, md} + 8'd1;
    case (ph)
      PH_FILL:  return FILL_S;
      PH_WASH:  return 8'(WASH_S * mult);
      PH_DRAIN: return DRAIN_S;
      PH_SPIN:  return SPIN_S;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      PH_FILL:  return PH_WASH;
      PH_WASH:  return PH_DRAIN;
      PH_DRAIN: return PH_SPIN;
      PH_SPIN:  return PH_DONE;
      default:  return PH_IDLE;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_IDLE;
      mode_q   <= 2'd0;
      remain_q <= 8'd0;
      paused_q <= 1'b0;
      presc_q  <= '0;
`ifdef WASH_BUZZER_EN
      buzz_q   <= 8'd0;
`endif
    end else begin
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
      paused_q <= paused_d;
      presc_q  <= presc_d;
`ifdef WASH_BUZZER_EN
      buzz_q   <= buzz_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    phase_d  = phase_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    paused_d = paused_q;
    presc_d  = presc_q;
`ifdef WASH_BUZZER_EN
    buzz_d   = buzz_q;
    buzzing  = (phase_q == PH_DONE) && (buzz_q != 8'd0);
`endif
    active   = (phase_q >= PH_FILL) && (phase_q <= PH_SPIN);
    run      = active && !paused_q;
`ifdef WASH_BUZZER_EN
    count_en = run || buzzing;
`else
    count_en = run;
`endif
    tick     = count_en && (presc_q == PRE_MAX);
    // A zero-length phase advances on the first running cycle.
    advance  = run && ((remain_q == 8'd0) || (tick && (remain_q == 8'd1)));
    next_ph  = next_phase(phase_q);

    if (count_en) presc_d = tick ? '0 : presc_q + 1'b1;

    if (key_stop) begin
      phase_d  = PH_IDLE;
      paused_d = 1'b0;
      remain_d = 8'd0;
      presc_d  = '0;
`ifdef WASH_BUZZER_EN
      buzz_d   = 8'd0;
`endif
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (key_start) begin
            phase_d  = PH_FILL;
            remain_d = phase_dur(PH_FILL, mode_q);
            presc_d  = '0;
            paused_d = 1'b0;
          end else if (key_mode) begin
            mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
          end
        end
        PH_DONE: begin
          if (key_start) begin
            phase_d  = PH_IDLE;
            remain_d = 8'd0;
            presc_d  = '0;
`ifdef WASH_BUZZER_EN
            buzz_d   = 8'd0;
          end else if (tick) begin
            buzz_d   = buzz_q - 8'd1;
`endif
          end
        end
        PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN: begin
          if (advance) begin
            phase_d  = next_ph;
            remain_d = phase_dur(next_ph, mode_q);
            presc_d  = '0;
`ifdef WASH_BUZZER_EN
            if (next_ph == PH_DONE) buzz_d = BUZZ_S;
`endif
          end else if (tick && (remain_q > 8'd1)) begin
            remain_d = remain_q - 8'd1;
          end
          // The tick is applied first; a start pulse on the same edge then
          // pauses whatever phase results (DONE is never paused).
          if (key_start) paused_d = (advance && (next_ph == PH_DONE)) ? 1'b0 : !paused_q;
        end
        default: begin
          phase_d  = PH_IDLE;
          remain_d = 8'd0;
          presc_d  = '0;
          paused_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    phase     = phase_q;
    mode      = mode_q;
    remain_s  = remain_q;
    paused    = paused_q;
    valve_in  = (phase_q == PH_FILL) && !paused_q;
    valve_out = ((phase_q == PH_DRAIN) || (phase_q == PH_SPIN)) && !paused_q;
    motor     = ((phase_q == PH_WASH) || (phase_q == PH_SPIN)) && !paused_q;
`ifdef WASH_BUZZER_EN
    buzzer    = buzzing;
`else
    buzzer    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wash_ctrl.sv
// Testbench for wash_ctrl: directed scenarios with literal expectations plus
// randomized key/reset stimulus, all compared every cycle against a
// cycle-count reference model of the washing program.
`timescale 1ns/1ps
module tb_wash_ctrl;

  localparam int         CLK_HZ  = 10;
  localparam logic [7:0] FILL_S  = 8'd2;
  localparam logic [7:0] WASH_S  = 8'd3;
  localparam logic [7:0] DRAIN_S = 8'd1;
  localparam logic [7:0] SPIN_S  = 8'd2;
  localparam logic [7:0] BUZZ_S  = 8'd1;
`ifdef WASH_BUZZER_EN
  localparam int BUZZ_EXP = 10;
`else
  localparam int BUZZ_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_stop = 1'b0;
  logic [2:0] phase;
  logic [1:0] mode;
  logic [7:0] remain_s;
  logic       paused, valve_in, valve_out, motor, buzzer;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wash_ctrl #(
    .CLK_HZ(CLK_HZ), .FILL_S(FILL_S), .WASH_S(WASH_S),
    .DRAIN_S(DRAIN_S), .SPIN_S(SPIN_S), .BUZZ_S(BUZZ_S)
  ) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_mode(key_mode),
    .key_stop(key_stop), .phase(phase), .mode(mode), .remain_s(remain_s),
    .paused(paused), .valve_in(valve_in), .valve_out(valve_out),
    .motor(motor), .buzzer(buzzer)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // The program is modelled as "cycles left in this phase": a phase of D
  // seconds lasts D*CLK_HZ running cycles and the displayed seconds are the
  // ceiling of cycles-left / CLK_HZ.
  int m_phase, m_mode, m_left, m_dur, m_buzz;
  bit m_paused;

  function automatic int dur_of(input int p, input int md);
    case (p)
      1: return int'(FILL_S);
      2: return int'(WASH_S) * (md + 1);
      3: return int'(DRAIN_S);
      4: return int'(SPIN_S);
      default: return 0;
    endcase
  endfunction

  function automatic int m_remain();
    if (m_phase >= 1 && m_phase <= 4 && m_dur != 0) return (m_left + CLK_HZ - 1) / CLK_HZ;
    return 0;
  endfunction

  task automatic m_enter(input int p);
    m_phase = p;
    m_dur   = dur_of(p, m_mode);
    m_left  = (m_dur == 0) ? 1 : m_dur * CLK_HZ;
    m_buzz  = 0;
`ifdef WASH_BUZZER_EN
    if (p == 5) m_buzz = int'(BUZZ_S) * CLK_HZ;
`endif
  endtask

  task automatic m_reset();
    m_phase = 0; m_mode = 0; m_left = 0; m_dur = 0; m_buzz = 0; m_paused = 0;
  endtask

  task automatic m_step(input bit st, input bit md, input bit sp);
    bit was_p;
    if (sp) begin
      m_phase = 0; m_paused = 0; m_buzz = 0; m_dur = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        m_enter(1);
        m_paused = 0;
      end else if (md) begin
        m_mode = (m_mode + 1) % 3;
      end
    end else if (m_phase == 5) begin
      if (st) begin
        m_phase = 0; m_buzz = 0; m_dur = 0;
      end else if (m_buzz > 0) begin
        m_buzz--;
      end
    end else begin
      was_p = m_paused;
      if (!was_p) begin
        m_left--;
        if (m_left == 0) m_enter(m_phase + 1);
      end
      if (st) m_paused = (m_phase == 5) ? 1'b0 : !was_p;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step(key_start, key_mode, key_stop);
    end
  end

  // Every-cycle comparison, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_phase", phase, m_phase);
      chk("cyc_mode", mode, m_mode);
      chk("cyc_remain", remain_s, m_remain());
      chk("cyc_paused", paused, m_paused);
      chk("cyc_valve_in", valve_in, (m_phase == 1) && !m_paused);
      chk("cyc_valve_out", valve_out, (m_phase == 3 || m_phase == 4) && !m_paused);
      chk("cyc_motor", motor, (m_phase == 2 || m_phase == 4) && !m_paused);
      chk("cyc_buzzer", buzzer, (m_phase == 5) && (m_buzz > 0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int mexp[4];
    int n, b, w, r;
    mexp = '{1, 2, 0, 1};

    #3;
    chk("rst_phase", phase, 0);
    chk("rst_mode", mode, 0);
    chk("rst_remain", remain_s, 0);
    chk("rst_paused", paused, 0);
    chk("rst_outs", {valve_in, valve_out, motor, buzzer}, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // mode cycling in IDLE
    for (int i = 0; i < 4; i++) begin
      key_mode = 1'b1; cyc(); key_mode = 1'b0;
      chk("mode_step", mode, mexp[i]);
    end
    key_mode = 1'b1; cyc(); cyc(); key_mode = 1'b0;
    chk("mode_back0", mode, 0);

    // quick program, full run to DONE
    key_start = 1'b1; cyc(); key_start = 1'b0;
    n = 0;
    chk("fill_phase", phase, 1);
    chk("fill_remain", remain_s, 2);
    chk("fill_valve", valve_in, 1);
    key_mode = 1'b1; cyc(); key_mode = 1'b0;
    n = 1;
    chk("mode_frozen", mode, 0);
    while (phase != 3'd5 && n < 200) begin
      cyc(); n++;
      if (n == 10) chk("fill_remain1", remain_s, 1);
      if (n == 20) begin
        chk("wash_phase", phase, 2);
        chk("wash_remain", remain_s, 3);
        chk("wash_motor", motor, 1);
        chk("model_wash_remain", m_remain(), 3);
      end
      if (n == 50) begin
        chk("drain_phase", phase, 3);
        chk("drain_valve", {valve_out, motor}, 2'b10);
      end
      if (n == 60) begin
        chk("spin_phase", phase, 4);
        chk("spin_outs", {valve_out, motor}, 2'b11);
      end
    end
    chk("done_latency", n, 80);
    chk("done_phase", phase, 5);
    chk("model_done", m_phase, 5);
    chk("done_remain", remain_s, 0);
    b = 0;
    for (int i = 0; i < 15; i++) begin
      if (buzzer) b++;
      cyc();
    end
    chk("buzz_cycles", b, BUZZ_EXP);
    key_start = 1'b1; cyc(); key_start = 1'b0;
    chk("done_ack", phase, 0);

    // heavy program with pause/resume
    key_mode = 1'b1; cyc(); cyc(); key_mode = 1'b0;
    chk("mode_heavy", mode, 2);
    key_start = 1'b1; cyc(); key_start = 1'b0;
    n = 0;
    while (phase != 3'd2 && n < 100) begin cyc(); n++; end
    chk("heavy_wash", phase, 2);
    chk("heavy_remain", remain_s, 9);
    w = 0;
    while (remain_s != 8'd2 && w < 200) begin cyc(); w++; end
    chk("heavy_to2", w, 70);
    key_start = 1'b1; cyc(); key_start = 1'b0;
    chk("pause_on", paused, 1);
    chk("pause_motor", motor, 0);
    chk("pause_remain", remain_s, 2);
    repeat (50) cyc();
    chk("pause_hold", {phase, remain_s, paused}, {3'd2, 8'd2, 1'b1});
    key_start = 1'b1; cyc(); key_start = 1'b0;
    r = 1;
    chk("resume", {paused, motor}, 2'b01);
    while (phase == 3'd2 && r < 100) begin cyc(); r++; end
    chk("resume_to_drain", r, 20);
    chk("drain_after", phase, 3);

    // stop + start together in SPIN
    n = 0;
    while (phase != 3'd4 && n < 100) begin cyc(); n++; end
    chk("reach_spin", phase, 4);
    repeat (3) cyc();
    key_stop = 1'b1; key_start = 1'b1; cyc(); key_stop = 1'b0; key_start = 1'b0;
    chk("stop_state", {phase, paused, remain_s}, 0);
    chk("stop_outs", {motor, valve_out}, 0);
    chk("stop_mode", mode, 2);

    // asynchronous reset mid-WASH
    key_start = 1'b1; cyc(); key_start = 1'b0;
    n = 0;
    while (phase != 3'd2 && n < 100) begin cyc(); n++; end
    chk("rst_reach_wash", phase, 2);
    repeat (5) cyc();
    #1 rst = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_mode", mode, 0);
    chk("arst_remain", remain_s, 0);
    chk("arst_outs", {paused, valve_in, valve_out, motor, buzzer}, 0);
    repeat (3) cyc();
    chk("arst_hold", {phase, motor}, 0);
    rst = 1'b1;
    cyc();
    chk("arst_release", phase, 0);

    // randomized keys and occasional resets
    for (int i = 0; i < 3000; i++) begin
      key_start = ($urandom_range(15) == 0);
      key_mode  = ($urandom_range(7) == 0);
      key_stop  = ($urandom_range(255) == 0);
      rst       = ($urandom_range(999) != 0);
      cyc();
    end
    key_start = 1'b0; key_mode = 1'b0; key_stop = 1'b0; rst = 1'b1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
